name_stream_reader: RTL and testbench

- Read-side sequencer for the 32x8 name memory.
- On Start, walks the memory from a start address, driving the memory's read strobe and address.
- Emits each character on a valid/ready byte stream (display/UART path).
- Stops at a terminator byte or after DEPTH characters, then pulses Done.

---
 rtl/name_mem_pkg.sv | 19 +
 rtl/name_stream_reader.sv | 142 ++++++++++++++
 tb/tb_name_stream_reader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/name_mem_pkg.sv
// Shared definitions for the 32x8 name memory and the blocks that access it
// (memory model, stream reader, future writer).
package name_mem_pkg;

    localparam int              NM_ADDR_W = 5;
    localparam int              NM_DATA_W = 8;
    localparam int              NM_DEPTH  = 32;
    localparam logic [7:0]      NM_TERM   = 8'h00;

    // Read-side sequencer states
    typedef enum logic [2:0] {
        NM_IDLE    = 3'd0,
        NM_ISSUE   = 3'd1,
        NM_WAIT    = 3'd2,
        NM_PRESENT = 3'd3,
        NM_DONE    = 3'd4
    } nm_state_e;

endpackage

// File: rtl/name_stream_reader.sv
// name_stream_reader: walks the name memory from StartAddr and streams each
// character over a valid/ready byte interface until a terminator byte or
// DEPTH characters, then pulses Done.
// Optional build macro NAME_STREAM_READER_ABORT_EN adds an Abort input that
// ends an in-flight stream early (Done still pulses, Count is kept).
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  IDLE    | waiting for Start; Count holds result of the last stream
//  ISSUE   | RNM high, Addr = ptr; memory captures data on this edge
//  WAIT    | registered ReadData is valid; test for terminator
//  PRESENT | OutValid high, OutData held until OutReady handshake
//  DONE    | one-cycle Done pulse, then back to IDLE
module name_stream_reader
    import name_mem_pkg::*;
#(
    parameter int                ADDR_W = NM_ADDR_W,
    parameter int                DATA_W = NM_DATA_W,
    parameter int                DEPTH  = NM_DEPTH,
    parameter logic [DATA_W-1:0] TERM   = NM_TERM
) (
    input  logic                Clk,
    input  logic                Rst,
`ifdef NAME_STREAM_READER_ABORT_EN
    input  logic                Abort,
`endif
    input  logic                Start,
    input  logic [ADDR_W-1:0]   StartAddr,
    output logic                RNM,
    output logic [ADDR_W-1:0]   Addr,
    input  logic [DATA_W-1:0]   ReadData,
    output logic [DATA_W-1:0]   OutData,
    output logic                OutValid,
    input  logic                OutReady,
    output logic                Busy,
    output logic                Done,
    output logic [ADDR_W:0]     Count
);

    localparam int CNT_W = ADDR_W + 1;

    localparam logic [2:0] ST_IDLE    = NM_IDLE;
    localparam logic [2:0] ST_ISSUE   = NM_ISSUE;
    localparam logic [2:0] ST_WAIT    = NM_WAIT;
    localparam logic [2:0] ST_PRESENT = NM_PRESENT;
    localparam logic [2:0] ST_DONE    = NM_DONE;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q,   ptr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              abort_w;
    logic [CNT_W-1:0]  count_inc;
    logic [ADDR_W-1:0] ptr_next;

`ifdef NAME_STREAM_READER_ABORT_EN
    assign abort_w = Abort;
`else
    assign abort_w = 1'b0;
`endif

    assign count_inc = count_q + CNT_W'(1);
    // Explicit wrap so a DEPTH smaller than 2**ADDR_W still stays in range
    assign ptr_next  = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);

    // Next-state, pointer, count and output-register decisions
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    ptr_d   = StartAddr;
                    count_d = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = abort_w ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (abort_w || ReadData == TERM) begin
                    state_d = ST_DONE;
                end else begin
                    data_d  = ReadData;
                    valid_d = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // Abort wins over a same-cycle handshake; that byte is dropped
                if (abort_w) begin
                    valid_d = 1'b0;
                    state_d = ST_DONE;
                end else if (OutReady) begin
                    valid_d = 1'b0;
                    count_d = count_inc;
                    ptr_d   = ptr_next;
                    state_d = (count_inc == CNT_W'(DEPTH)) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by Rst
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign RNM      = (state_q == ST_ISSUE);
    assign Addr     = ptr_q;
    assign OutData  = data_q;
    assign OutValid = valid_q;
    assign Busy     = (state_q != ST_IDLE);
    assign Done     = (state_q == ST_DONE);
    assign Count    = count_q;

endmodule

// File: tb/tb_name_stream_reader.sv
// Directed bench for name_stream_reader with a behavioural registered-read
// name memory and a negedge monitor that logs reads, handshakes and Done.
module tb_name_stream_reader;

    logic       Clk = 1'b0;
    logic       Rst, Start, OutReady;
    logic [4:0] StartAddr, Addr;
    logic [7:0] ReadData, OutData;
    logic       RNM, OutValid, Busy, Done;
    logic [5:0] Count;
`ifdef NAME_STREAM_READER_ABORT_EN
    logic       Abort;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    name_stream_reader dut (
        .Clk       (Clk),
        .Rst       (Rst),
`ifdef NAME_STREAM_READER_ABORT_EN
        .Abort     (Abort),
`endif
        .Start     (Start),
        .StartAddr (StartAddr),
        .RNM       (RNM),
        .Addr      (Addr),
        .ReadData  (ReadData),
        .OutData   (OutData),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .Busy      (Busy),
        .Done      (Done),
        .Count     (Count)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [32];
    always @(posedge Clk) if (RNM === 1'b1) ReadData <= mem[Addr];

    // monitor logs (totals only increase; the stimulus takes snapshots)
    int         cyc = 0;
    int         rnm_total = 0, hs_total = 0, done_total = 0, vrise_total = 0, stall_viol = 0;
    logic [4:0] addr_log [256];
    int         rnm_cyc [256];
    logic [7:0] byte_log [256];
    int         done_cyc [256];
    int         vrise_cyc [256];
    logic       prev_valid = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge Clk) begin
        cyc++;
        if (RNM === 1'b1) begin
            addr_log[rnm_total] = Addr;
            rnm_cyc[rnm_total] = cyc;
            rnm_total++;
        end
        if (OutValid === 1'b1 && OutReady === 1'b1) begin
            byte_log[hs_total] = OutData;
            hs_total++;
        end
        if (Done === 1'b1) begin
            done_cyc[done_total] = cyc;
            done_total++;
        end
        if (OutValid === 1'b1 && !prev_valid) begin
            vrise_cyc[vrise_total] = cyc;
            vrise_total++;
        end
        if (prev_stall && !(OutValid === 1'b1 && OutData === prev_data)) stall_viol++;
        prev_stall = (OutValid === 1'b1) && (OutReady !== 1'b1);
        prev_valid = (OutValid === 1'b1);
        prev_data  = OutData;
    end

    int rb, hb, db, vb, sb;

    task automatic snap();
        rb = rnm_total; hb = hs_total; db = done_total; vb = vrise_total; sb = stall_viol;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        bit seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (OutValid === 1'b1) begin seen = 1; break; end
            @(posedge Clk); #1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    // Pulse Start, then drive OutReady (stalling 5 cycles per byte if asked)
    // until Done is seen; optionally re-assert Start on iteration 'inject'.
    task automatic run_stream(input logic [4:0] sa, input bit stall, input int inject);
        int wait_n = 0;
        bit seen = 0;
        @(posedge Clk); #1;
        Start = 1'b1; StartAddr = sa; OutReady = !stall;
        @(posedge Clk); #1;
        Start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (Done === 1'b1) begin seen = 1; break; end
            if (k == inject) begin Start = 1'b1; StartAddr = 5'd7; end
            else Start = 1'b0;
            if (stall) begin
                if (OutValid === 1'b1) begin
                    if (wait_n < 5) begin OutReady = 1'b0; wait_n++; end
                    else begin OutReady = 1'b1; wait_n = 0; end
                end else OutReady = 1'b0;
            end else OutReady = 1'b1;
            @(posedge Clk); #1;
        end
        check("done_seen", 32'(seen), 32'd1);
        Start = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic load_bob();
        for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
        mem[0] = 8'h42; mem[1] = 8'h4F; mem[2] = 8'h42; mem[3] = 8'h00;
    endtask

    initial begin
        int ok;
        logic [4:0] wrap_addr [5];
        logic [7:0] wrap_byte [4];
        wrap_addr[0] = 5'd30; wrap_addr[1] = 5'd31; wrap_addr[2] = 5'd0;
        wrap_addr[3] = 5'd1;  wrap_addr[4] = 5'd2;
        wrap_byte[0] = 8'h7E; wrap_byte[1] = 8'h7F; wrap_byte[2] = 8'h60; wrap_byte[3] = 8'h61;

        Rst = 1'b1; Start = 1'b0; OutReady = 1'b0; StartAddr = 5'd0;
`ifdef NAME_STREAM_READER_ABORT_EN
        Abort = 1'b0;
`endif
        load_bob();
        repeat (3) @(posedge Clk);
        #1;
        check("rst_outvalid", 32'(OutValid), 32'd0);
        check("rst_busy",     32'(Busy),     32'd0);
        Rst = 1'b0;
        #1;
        check("rst_rnm",     32'(RNM),     32'd0);
        check("rst_addr",    32'(Addr),    32'd0);
        check("rst_outdata", 32'(OutData), 32'd0);
        check("rst_done",    32'(Done),    32'd0);
        check("rst_count",   32'(Count),   32'd0);

        // BOB, OutReady tied high
        snap();
        run_stream(5'd0, 1'b0, -1);
        check("bob_hs",    32'(hs_total - hb),   32'd3);
        check("bob_b0",    32'(byte_log[hb]),    32'h42);
        check("bob_b1",    32'(byte_log[hb+1]),  32'h4F);
        check("bob_b2",    32'(byte_log[hb+2]),  32'h42);
        check("bob_rnm",   32'(rnm_total - rb),  32'd4);
        for (int i = 0; i < 4; i++) check("bob_addr", 32'(addr_log[rb+i]), 32'(i));
        check("bob_done",  32'(done_total - db), 32'd1);
        check("bob_count", 32'(Count),           32'd3);
        check("bob_lat",   32'(vrise_cyc[vb] - rnm_cyc[rb]), 32'd2);
        check("bob_idle",  32'(Busy),            32'd0);

        // BOB with 5-cycle stalls and a Start while busy
        snap();
        run_stream(5'd0, 1'b1, 4);
        check("stl_stable", 32'(stall_viol - sb), 32'd0);
        check("stl_rnm",    32'(rnm_total - rb),  32'd4);
        check("stl_hs",     32'(hs_total - hb),   32'd3);
        check("stl_b0",     32'(byte_log[hb]),    32'h42);
        check("stl_b1",     32'(byte_log[hb+1]),  32'h4F);
        check("stl_b2",     32'(byte_log[hb+2]),  32'h42);
        check("stl_count",  32'(Count),           32'd3);
        check("stl_done",   32'(done_total - db), 32'd1);

        // 32 x 'A', no terminator
        for (int i = 0; i < 32; i++) mem[i] = 8'h41;
        snap();
        run_stream(5'd0, 1'b0, -1);
        check("full_hs",    32'(hs_total - hb),   32'd32);
        check("full_rnm",   32'(rnm_total - rb),  32'd32);
        check("full_done",  32'(done_total - db), 32'd1);
        check("full_count", 32'(Count),           32'd32);
        ok = 0;
        for (int i = 0; i < 32; i++)
            if (addr_log[rb+i] === 5'(i) && byte_log[hb+i] === 8'h41) ok++;
        check("full_seq", 32'(ok), 32'd32);

        // Wrap 30,31,0,1 then terminator at 2
        for (int i = 0; i < 32; i++) mem[i] = 8'h60 + 8'(i);
        mem[2] = 8'h00;
        snap();
        run_stream(5'd30, 1'b0, -1);
        check("wrap_rnm",   32'(rnm_total - rb), 32'd5);
        for (int i = 0; i < 5; i++) check("wrap_addr", 32'(addr_log[rb+i]), 32'(wrap_addr[i]));
        check("wrap_hs",    32'(hs_total - hb),  32'd4);
        for (int i = 0; i < 4; i++) check("wrap_byte", 32'(byte_log[hb+i]), 32'(wrap_byte[i]));
        check("wrap_count", 32'(Count),          32'd4);
        check("wrap_done",  32'(done_total - db), 32'd1);

        // Terminator at the start address
        mem[7] = 8'h00;
        snap();
        run_stream(5'd7, 1'b0, -1);
        check("term_rnm",   32'(rnm_total - rb),   32'd1);
        check("term_valid", 32'(vrise_total - vb), 32'd0);
        check("term_hs",    32'(hs_total - hb),    32'd0);
        check("term_done",  32'(done_total - db),  32'd1);
        check("term_lat",   32'(done_cyc[db] - rnm_cyc[rb]), 32'd2);
        check("term_count", 32'(Count),            32'd0);

        // Reset while presenting the second character
        load_bob();
        OutReady = 1'b0;
        @(posedge Clk); #1;
        Start = 1'b1; StartAddr = 5'd0;
        @(posedge Clk); #1;
        Start = 1'b0;
        wait_valid("rst_wait1");
        OutReady = 1'b1;
        @(posedge Clk); #1;
        OutReady = 1'b0;
        wait_valid("rst_wait2");
        check("rst_pre_count", 32'(Count),   32'd1);
        check("rst_pre_data",  32'(OutData), 32'h4F);
        snap();
        Rst = 1'b1;
        #1;
        check("rstm_valid", 32'(OutValid), 32'd0);
        check("rstm_busy",  32'(Busy),     32'd0);
        check("rstm_count", 32'(Count),    32'd0);
        check("rstm_rnm",   32'(RNM),      32'd0);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rstm_nodone", 32'(done_total - db), 32'd0);

`ifdef NAME_STREAM_READER_ABORT_EN
        // Abort with a same-cycle handshake on the second character
        OutReady = 1'b0;
        @(posedge Clk); #1;
        Start = 1'b1; StartAddr = 5'd0;
        @(posedge Clk); #1;
        Start = 1'b0;
        wait_valid("abt_wait1");
        OutReady = 1'b1;
        @(posedge Clk); #1;
        OutReady = 1'b0;
        wait_valid("abt_wait2");
        Abort = 1'b1; OutReady = 1'b1;
        @(posedge Clk); #1;
        Abort = 1'b0; OutReady = 1'b0;
        check("abt_done",  32'(Done),     32'd1);
        check("abt_valid", 32'(OutValid), 32'd0);
        check("abt_count", 32'(Count),    32'd1);
        @(posedge Clk); #1;
        check("abt_idle",  32'(Busy),     32'd0);
        check("abt_hold",  32'(Count),    32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
